// File: rtl/vc_fifo_pkg.sv
// Shared defaults and helpers for the virtual-channel FIFO bank.
// Optional head-of-queue peek port is enabled by defining VC_FIFO_PEEK_EN.
package vc_fifo_pkg;

  localparam int unsigned DefDataWidth = 6;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefNumVc     = 2;
  localparam int unsigned DefThrWidth  = 4;
  localparam int unsigned MaxThrBits   = 256;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single VC still needs a 1-bit select.
  function automatic int unsigned vc_sel_w(input int unsigned n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

  function automatic logic [31:0] thr_slice(input logic [MaxThrBits-1:0] vec,
                                            input int unsigned v,
                                            input int unsigned w);
    logic [MaxThrBits-1:0] sh;
    logic [31:0]           mask;
    sh   = vec >> (v * w);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Write/read/status bundle between the TLP source, the VC arbiter and the FIFO bank.
// head_data exists only when VC_FIFO_PEEK_EN is defined.
interface vc_fifo_bank_if
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_VC     = DefNumVc,
  parameter int unsigned THR_WIDTH  = DefThrWidth
);
  localparam int unsigned VC_SEL_W = vc_sel_w(NUM_VC);

  logic                          wr_enable;
  logic [VC_SEL_W-1:0]           wr_vc;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          rd_enable;
  logic [VC_SEL_W-1:0]           rd_vc;
  logic [NUM_VC*THR_WIDTH-1:0]   umbral_af;
  logic [NUM_VC*THR_WIDTH-1:0]   umbral_ae;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          data_out_valid;
  logic [NUM_VC-1:0]             full;
  logic [NUM_VC-1:0]             empty;
  logic [NUM_VC-1:0]             almost_full;
  logic [NUM_VC-1:0]             almost_empty;
  logic [NUM_VC-1:0]             error;
`ifdef VC_FIFO_PEEK_EN
  logic [NUM_VC*DATA_WIDTH-1:0]  head_data;
`endif

  modport master (
    output wr_enable, wr_vc, data_in, rd_enable, rd_vc, umbral_af, umbral_ae,
    input  data_out, data_out_valid, full, empty, almost_full, almost_empty, error
`ifdef VC_FIFO_PEEK_EN
    , input head_data
`endif
  );

  modport slave (
    input  wr_enable, wr_vc, data_in, rd_enable, rd_vc, umbral_af, umbral_ae,
    output data_out, data_out_valid, full, empty, almost_full, almost_empty, error
`ifdef VC_FIFO_PEEK_EN
    , output head_data
`endif
  );

endinterface

// File: rtl/vc_fifo_channel.sv
// One virtual channel: storage, pointers, occupancy, threshold flags and sticky error.
// clr_n is the combined reset/init; flags are forced to their idle values while it is low.
module vc_fifo_channel
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned THR_WIDTH  = DefThrWidth
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [THR_WIDTH-1:0]  umbral_af,
  input  logic [THR_WIDTH-1:0]  umbral_ae,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  error_q, error_d;
  logic                  full_raw, empty_raw, wr_ok, rd_ok;
  logic [31:0]           af_thr, af_lim;

  assign full_raw  = (cnt_q == CntW'(Depth));
  assign empty_raw = (cnt_q == '0);
  assign wr_ok     = wr_req && !full_raw;
  assign rd_ok     = rd_req && !empty_raw;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    if (!clr_n) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      error_d  = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      error_d = error_q | (wr_req & full_raw) | (rd_req & empty_raw);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    cnt_q    <= cnt_d;
    error_q  <= error_d;
  end

  // Storage is never cleared; only the pointers are.
  always_ff @(posedge clk) begin
    if (clr_n && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  // Threshold at or above DEPTH saturates the almost-full limit at 0.
  always_comb begin
    af_thr       = 32'(umbral_af);
    af_lim       = (af_thr >= Depth) ? 32'd0 : (Depth - af_thr);
    full         = clr_n & full_raw;
    empty        = ~clr_n | empty_raw;
    almost_full  = clr_n & (32'(cnt_q) >= af_lim) & ~full_raw;
    almost_empty = clr_n & ~empty_raw & (32'(cnt_q) <= 32'(umbral_ae));
    head         = mem_q[rd_ptr_q];
    error        = error_q;
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs with shared, VC-steered write and read ports.
// Define VC_FIFO_PEEK_EN to expose each VC's head word on bus.head_data.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_VC     = DefNumVc,
  parameter int unsigned THR_WIDTH  = DefThrWidth
) (
  input logic           clk,
  input logic           reset,
  input logic           init,
  vc_fifo_bank_if.slave bus
);
  logic                  clr_n;
  logic [NUM_VC-1:0]     wr_hit, rd_hit;
  logic [NUM_VC-1:0]     full, empty, almost_full, almost_empty, error;
  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;

  assign clr_n = reset & init;

  // Out-of-range selects match no channel, so they are silently ignored.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = bus.wr_enable && (32'(bus.wr_vc) == v);
      rd_hit[v] = bus.rd_enable && (32'(bus.rd_vc) == v);
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_chan
    vc_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .THR_WIDTH  (THR_WIDTH)
    ) u_chan (
      .clk          (clk),
      .clr_n        (clr_n),
      .wr_req       (wr_hit[g]),
      .rd_req       (rd_hit[g]),
      .data_in      (bus.data_in),
      .umbral_af    (THR_WIDTH'(thr_slice(MaxThrBits'(bus.umbral_af), g, THR_WIDTH))),
      .umbral_ae    (THR_WIDTH'(thr_slice(MaxThrBits'(bus.umbral_ae), g, THR_WIDTH))),
      .head         (head[g]),
      .full         (full[g]),
      .empty        (empty[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .error        (error[g])
    );
  end

  always_comb begin
    rd_fire = 1'b0;
    rd_word = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (rd_hit[v] && !empty[v]) begin
        rd_fire = 1'b1;
        rd_word = head[v];
      end
    end
    valid_d    = clr_n & rd_fire;
    data_out_d = valid_d ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
    valid_q    <= valid_d;
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.almost_full    = almost_full;
  assign bus.almost_empty   = almost_empty;
  assign bus.error          = error;

`ifdef VC_FIFO_PEEK_EN
  always_comb begin
    bus.head_data = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      bus.head_data[v*DATA_WIDTH +: DATA_WIDTH] = empty[v] ? '0 : head[v];
    end
  end
`endif

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank: expected read words go into a scoreboard queue,
// a negedge monitor pops and compares every valid output word.
module tb_vc_fifo_bank;
  import vc_fifo_pkg::*;

  localparam int unsigned DW = 6;
  localparam int unsigned AW = 4;
  localparam int unsigned NV = 2;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic init;

  always #5 clk = ~clk;

  vc_fifo_bank_if #(.DATA_WIDTH(DW), .NUM_VC(NV), .THR_WIDTH(TW)) bus ();

  vc_fifo_bank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_VC     (NV),
    .THR_WIDTH  (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] model0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.data_out_valid === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_valid", 32'(bus.data_out_valid), 32'd0);
      else chk("data_out", 32'(bus.data_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
  endtask

  task automatic wr(input logic [0:0] vc, input logic [DW-1:0] d);
    bus.wr_enable = 1'b1;
    bus.wr_vc     = vc;
    bus.data_in   = d;
  endtask

  task automatic rd(input logic [0:0] vc);
    bus.rd_enable = 1'b1;
    bus.rd_vc     = vc;
  endtask

  initial begin
    logic [DW-1:0] d;
    reset         = 1'b0;
    init          = 1'b1;
    bus.umbral_af = 8'h04;  // VC0 = 4, VC1 = 0
    bus.umbral_ae = 8'h05;  // VC0 = 5, VC1 = 0
    wr(1'b0, 6'h3F);
    rd(1'b1);

    // 1: reset with traffic present
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty), 32'h3);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_af", 32'(bus.almost_full), 32'h0);
    chk("rst_ae", 32'(bus.almost_empty), 32'h0);
    chk("rst_error", 32'(bus.error), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_valid", 32'(bus.data_out_valid), 32'h0);
    idle();
    reset = 1'b1;
    tick();

    // 2: fill VC0 to full and overflow it
    for (int i = 1; i <= 16; i++) begin
      wr(1'b0, DW'(i));
      model0.push_back(DW'(i));
      tick();
      chk("fill_af0", 32'(bus.almost_full[0]), 32'((i >= 12) && (i < 16)));
      chk("fill_full0", 32'(bus.full[0]), 32'(i == 16));
      chk("fill_ae0", 32'(bus.almost_empty[0]), 32'(i <= 5));
    end
    chk("fill_err0", 32'(bus.error[0]), 32'h0);
    wr(1'b0, 6'h11);
    tick();
    chk("ovf_err0", 32'(bus.error[0]), 32'h1);
    chk("ovf_full0", 32'(bus.full[0]), 32'h1);
    chk("ovf_vc1_empty", 32'(bus.empty[1]), 32'h1);
    chk("ovf_vc1_af", 32'(bus.almost_full[1]), 32'h0);
    idle();
    for (int i = 0; i < 16; i++) begin
      rd(1'b0);
      sb_q.push_back(model0.pop_front());
      tick();
    end
    idle();
    tick();
    chk("drain_empty0", 32'(bus.empty[0]), 32'h1);
    chk("drain_err0_sticky", 32'(bus.error[0]), 32'h1);

    // 3: single word through VC1
    wr(1'b1, 6'h2A);
    tick();
    idle();
`ifdef VC_FIFO_PEEK_EN
    chk("peek_vc1", 32'(bus.head_data[DW +: DW]), 32'h2A);
`endif
    rd(1'b1);
    sb_q.push_back(6'h2A);
    tick();
    idle();
    chk("vc1_empty_after_rd", 32'(bus.empty[1]), 32'h1);
    tick();
    tick();

    // 4: underflow, then write+read on an empty VC
    init = 1'b0;
    tick();
    init = 1'b1;
    chk("init_err_clear", 32'(bus.error), 32'h0);
    rd(1'b0);
    tick();
    idle();
    chk("udf_err0", 32'(bus.error[0]), 32'h1);
    chk("udf_valid", 32'(bus.data_out_valid), 32'h0);
    wr(1'b0, 6'h33);
    rd(1'b0);
    model0.push_back(6'h33);
    tick();
    idle();
    chk("wr_rd_empty_notempty", 32'(bus.empty[0]), 32'h0);
    chk("wr_rd_empty_valid", 32'(bus.data_out_valid), 32'h0);
    chk("wr_rd_empty_ae", 32'(bus.almost_empty[0]), 32'h1);
    chk("wr_rd_empty_err0", 32'(bus.error[0]), 32'h1);

    // 5: hold VC0 at five entries while streaming across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, DW'(8'h34 + i));
      model0.push_back(DW'(8'h34 + i));
      tick();
    end
    idle();
    for (int i = 0; i < 40; i++) begin
      d = DW'(8'h38 + i);
      wr(1'b0, d);
      rd(1'b0);
      sb_q.push_back(model0.pop_front());
      model0.push_back(d);
      tick();
      chk("stream_ae0", 32'(bus.almost_empty[0]), 32'h1);
      chk("stream_empty0", 32'(bus.empty[0]), 32'h0);
    end
    idle();
    tick();

    // 6: init discards contents and clears error
    wr(1'b0, 6'h01);
    tick();
    wr(1'b0, 6'h02);
    tick();
    idle();
    chk("pre_init_err0", 32'(bus.error[0]), 32'h1);
    chk("pre_init_ae0", 32'(bus.almost_empty[0]), 32'h0);
    init = 1'b0;
    tick();
    init = 1'b1;
    model0.delete();
    chk("post_init_empty0", 32'(bus.empty[0]), 32'h1);
    chk("post_init_err0", 32'(bus.error[0]), 32'h0);
    rd(1'b0);
    tick();
    idle();
    chk("post_init_rd_valid", 32'(bus.data_out_valid), 32'h0);
    wr(1'b0, 6'h15);
    tick();
    idle();
    rd(1'b0);
    sb_q.push_back(6'h15);
    tick();
    idle();
    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
Parametrised bank of NUM_VC independent virtual-channel FIFOs for the PCIe transmit layer. It generalises the single-VC FIFO with a shared write port, a shared read port (each steered by a VC select), and per-VC programmable almost-full/almost-empty thresholds and status flags. It sits between the transaction-layer packet source and the VC arbiter; the arbiter uses per-VC flags to pick rd_vc.

Parameters:
DATA_WIDTH, 6, width of one FIFO word
ADDR_WIDTH, 4, log2 of per-VC depth (DEPTH = 2**ADDR_WIDTH)
NUM_VC, 2, number of virtual channels (1..8)
THR_WIDTH, 4, width of each per-VC threshold field

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-low reset
init  in  1  synchronous, active-low soft init; same effect as reset
wr_enable  in  1  write request
wr_vc  in  VC_SEL_W  target VC of write (VC_SEL_W = max(1, clog2(NUM_VC)))
data_in  in  DATA_WIDTH  write data
rd_enable  in  1  read request
rd_vc  in  VC_SEL_W  source VC of read
umbral_af  in  NUM_VC*THR_WIDTH  per-VC almost-full threshold; VC v at [v*THR_WIDTH +: THR_WIDTH]
umbral_ae  in  NUM_VC*THR_WIDTH  per-VC almost-empty threshold, same packing
data_out  out  DATA_WIDTH  read data (registered)
data_out_valid  out  1  data_out holds a popped word this cycle
full  out  NUM_VC  per-VC full
empty  out  NUM_VC  per-VC empty
almost_full  out  NUM_VC  per-VC almost full
almost_empty  out  NUM_VC  per-VC almost empty
error  out  NUM_VC  per-VC sticky overflow/underflow

Behaviour:
- Per VC: DEPTH-entry memory, wr_ptr/rd_ptr ADDR_WIDTH bits (natural wrap), cnt ADDR_WIDTH+1 bits.
- Reset/init: if reset==0 or init==0 at posedge: all ptrs and cnts = 0, data_out = 0, data_out_valid = 0, error = 0. Memory not cleared. While either is low, flags forced combinationally: empty = all 1, full/almost_full/almost_empty = 0. Mid-operation assertion discards all contents at that edge.
- Flags are combinational from cnt: full = (cnt==DEPTH); empty = (cnt==0); almost_full = cnt >= DEPTH - umbral_af[v] and cnt < DEPTH; subtraction is done in ADDR_WIDTH+1 bits and saturates at 0 when umbral_af >= DEPTH. almost_empty = cnt != 0 and cnt <= umbral_ae[v].
- Write: accepted when wr_enable and full[wr_vc]==0 (pre-edge value). Stores data_in at wr_ptr, wr_ptr+1, cnt+1. Write to a full VC is dropped and sets error[wr_vc]. A simultaneous read of the same VC does not rescue it.
- Read: accepted when rd_enable and empty[rd_vc]==0 (pre-edge value). At the edge, data_out <= mem[rd_ptr], data_out_valid <= 1, rd_ptr+1, cnt-1. Latency is 1 cycle from request to data. Read from an empty VC sets error[rd_vc]. A same-cycle write to that VC does not bypass.
- Any cycle with no accepted read: data_out <= 0, data_out_valid <= 0.
- Same VC, both accepted: cnt unchanged, both pointers advance. Different VCs: fully independent.
- wr_vc or rd_vc >= NUM_VC: request ignored, no error.
- error[v] is sticky until reset/init. It never blocks operation.

Optional Feature:
VC_FIFO_PEEK_EN:
- Defined: adds output head_data [NUM_VC*DATA_WIDTH]. Slice v = mem_v[rd_ptr_v], combinational, forced 0 when empty[v] or during reset/init. Used by the arbiter to inspect packet headers before popping.
- Undefined: port and logic absent. Behaviour is otherwise identical.

Decomposition:
- Package vc_fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH/NUM_VC/THR_WIDTH constants
  - clog2 function and the VC_SEL_W derivation
  - a threshold-slice helper function
- Sub-module vc_fifo_channel: one VC's storage, pointers, cnt, flags and sticky error. Instantiated NUM_VC times via generate.
- Top level: wr/rd decode, read-data mux and output register.

Test Plan:
1. reset=0 for 2 cycles with traffic on inputs -> empty=2'b11, full=0, almost_*=0, error=0, data_out=0, data_out_valid=0.
2. umbral_af[0]=4: write 0x01..0x10 to VC0 -> almost_full[0] rises after 12th write, full[0] after 16th. 17th write is dropped, error[0]=1. VC1 flags unchanged.
3. Write 0x2A to VC1, next cycle read VC1 -> one cycle later data_out=0x2A, data_out_valid=1 for exactly one cycle, empty[1]=1.
4. Read empty VC0 -> data_out_valid=0, error[0]=1. Write+read VC0 same cycle while empty -> cnt=1, error[0]=1, no data popped.
5. VC0 at cnt=5, umbral_ae[0]=5: simultaneous write/read to VC0 for 40 cycles with incrementing data -> cnt stays 5, almost_empty[0]=1 throughout, data returned in order across pointer wrap.
6. VC0 cnt=7, error[0]=1, init=0 for 1 cycle -> next cycle empty[0]=1, error[0]=0. A subsequent read returns nothing; a new write/read returns the new data.
